// File: rtl/cla_adder32_pipe_if.sv
// cla_adder32_pipe_if: operand/result valid-ready bundle for cla_adder32_pipe
//   in_valid/in_ready : operand beat handshake (a, b, sub, cin)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf, zero)
//   master drives operands and accepts results; slave is the adder
interface cla_adder32_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );
   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_adder32_pipe.sv
// cla_adder32_pipe: two-stage pipelined carry-lookahead add/subtract unit
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of cla_adder32_pipe_if (operands in, result + cout/ovf/zero out)
module cla_adder32_pipe #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   cla_adder32_pipe_if.slave bus
);
   localparam int NG = WIDTH / 4;
   localparam int NS = WIDTH / 16;

   // 4-bit lookahead: returns carries into bits 0..3 plus the carry out in [4]
   function automatic logic [4:0] la4(input logic [3:0] p, input logic [3:0] g, input logic c);
      logic [4:0] r;
      r[0] = c;
      r[1] = g[0] | (p[0] & c);
      r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c);
      return r;
   endfunction

   logic [WIDTH-1:0] bb, p_d, g_d, p_q, g_q;
   logic [NG-1:0]    gp_d, gg_d, gp_q, gg_q;
   logic             c0_d, c0_q, am_q, bm_q;
   logic             s1_valid_q, s2_valid_q;
   logic [4:0]       t1, t2;
   logic [NS:0]      sc;
   logic [NG-1:0]    gcin;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, ovf_d, zero_d, cout_q, ovf_q, zero_q;
   logic             adv1, adv2;

   always_comb begin
      bb   = bus.sub ? ~bus.b : bus.b;
      c0_d = bus.sub | bus.cin;
      p_d  = bus.a ^ bb;
      g_d  = bus.a & bb;
      gp_d = '0;
      gg_d = '0;
      t1   = '0;
      for (int k = 0; k < NG; k++) begin
         t1      = la4(p_d[4*k +: 4], g_d[4*k +: 4], 1'b0);
         gp_d[k] = &p_d[4*k +: 4];
         gg_d[k] = t1[4];
      end
   end

   // Super-groups chain their carry-outs; each resolves its four group carry-ins,
   // then each group resolves its four bit carries from its own carry-in.
   always_comb begin
      sc    = '0;
      gcin  = '0;
      c     = '0;
      t2    = '0;
      sc[0] = c0_q;
      for (int j = 0; j < NS; j++) begin
         t2               = la4(gp_q[4*j +: 4], gg_q[4*j +: 4], sc[j]);
         gcin[4*j +: 4]   = t2[3:0];
         sc[j+1]          = t2[4];
      end
      for (int k = 0; k < NG; k++) begin
         t2             = la4(p_q[4*k +: 4], g_q[4*k +: 4], gcin[k]);
         c[4*k +: 4]    = t2[3:0];
         c[4*k+4]       = t2[4];
      end
      sum_d  = p_q ^ c[WIDTH-1:0];
      cout_d = c[WIDTH];
      ovf_d  = (am_q == bm_q) && (sum_d[WIDTH-1] != am_q);
      zero_d = ~|sum_d;
   end

   assign adv2 = !s2_valid_q | bus.out_ready;
   assign adv1 = !s1_valid_q | adv2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         if (adv1) s1_valid_q <= bus.in_valid;
         if (adv1 && bus.in_valid) begin
            p_q  <= p_d;
            g_q  <= g_d;
            gp_q <= gp_d;
            gg_q <= gg_d;
            c0_q <= c0_d;
            am_q <= bus.a[WIDTH-1];
            bm_q <= bb[WIDTH-1];
         end
         if (adv2) s2_valid_q <= s1_valid_q;
         if (adv2 && s1_valid_q) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = s2_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
